// File: rtl/inst_loader_pkg.sv
// Shared definitions for the debug instruction loader: command bytes, FSM states, end-of-program word.
package inst_loader_pkg;

   localparam int unsigned CMD_W = 8;

   localparam logic [CMD_W-1:0] CMD_LOAD = 8'h4C;
   localparam logic [CMD_W-1:0] CMD_RUN  = 8'h52;
   localparam logic [CMD_W-1:0] CMD_STEP = 8'h53;

   localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs an RX byte stream big-endian into words; word_valid pulses for one cycle per finished word.
module inst_loader_byte_packer #(
   parameter int unsigned NBITS   = 32,
   parameter int unsigned NB_BYTE = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               byte_valid,
   input  logic [NB_BYTE-1:0] byte_data,
   output logic               word_valid,
   output logic [NBITS-1:0]   word,
   output logic               done_c,
   output logic [NBITS-1:0]   word_c
);

   localparam int unsigned SHIFT_W  = NBITS - NB_BYTE;
   localparam logic [1:0]  LAST_CNT = 2'(NBITS / NB_BYTE - 1);

   logic [1:0]         cnt;
   logic [SHIFT_W-1:0] shift;

   // Word as it stands once the current byte is included; the top needs it at the same edge.
   assign word_c = {shift, byte_data};
   assign done_c = byte_valid && (cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt        <= '0;
         shift      <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= 1'b0;
         if (clr) begin
            cnt   <= '0;
            shift <= '0;
         end else if (byte_valid) begin
            shift <= word_c[SHIFT_W-1:0];
            cnt   <= cnt + 2'd1;
            if (done_c) begin
               word_valid <= 1'b1;
               word       <= word_c;
            end
         end
      end
   end

endmodule

// File: rtl/inst_loader.sv
// Debug loader: writes a UART byte stream into instruction memory, then gates pipeline run/step.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int unsigned      NBITS      = 32,
   parameter int unsigned      NB_BYTE    = 8,
   parameter int unsigned      MEM_DEPTH  = 256,
   parameter logic [NBITS-1:0] HALT_INSTR = NBITS'(HALT_INSTR_DEFAULT)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_BYTE-1:0] i_rx_data,
   input  logic               i_rx_valid,
   input  logic               i_halt_reached,
   output logic               o_inst_mem_wr_en,
   output logic [NBITS-1:0]   o_inst_mem_addr,
   output logic [NBITS-1:0]   o_inst_mem_data,
   output logic               o_enable,
   output logic               o_loaded,
   output logic               o_overflow,
   output logic [1:0]         o_state
);

   localparam logic [NBITS-1:0] LAST_ADDR = NBITS'((MEM_DEPTH - 1) * 4);

   state_t           state;
   logic [NBITS-1:0] addr;
   logic             pk_clr;
   logic             pk_byte_valid;
   logic             pk_done_c;
   logic [NBITS-1:0] pk_word_c;

   assign pk_byte_valid = i_rx_valid && (state == ST_LOAD);
   assign pk_clr        = i_rx_valid && (state == ST_IDLE) && (i_rx_data == NB_BYTE'(CMD_LOAD));

   inst_loader_byte_packer #(
      .NBITS   (NBITS),
      .NB_BYTE (NB_BYTE)
   ) u_packer (
      .clk        (i_clk),
      .rst        (i_rst),
      .clr        (pk_clr),
      .byte_valid (pk_byte_valid),
      .byte_data  (i_rx_data),
      .word_valid (o_inst_mem_wr_en),
      .word       (o_inst_mem_data),
      .done_c     (pk_done_c),
      .word_c     (pk_word_c)
   );

   assign o_inst_mem_addr = addr;
   assign o_state         = state;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state      <= ST_IDLE;
         addr       <= '0;
         o_enable   <= 1'b0;
         o_loaded   <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         // Address moves on only after its write cycle and saturates at the last word.
         if (o_inst_mem_wr_en && (addr != LAST_ADDR)) begin
            addr <= addr + NBITS'(4);
         end
         unique case (state)
            ST_IDLE: begin
               if (i_rx_valid) begin
                  if (i_rx_data == NB_BYTE'(CMD_LOAD)) begin
                     state      <= ST_LOAD;
                     addr       <= '0;
                     o_loaded   <= 1'b0;
                     o_overflow <= 1'b0;
                  end else if (o_loaded && (i_rx_data == NB_BYTE'(CMD_RUN))) begin
                     state    <= ST_RUN;
                     o_enable <= 1'b1;
                  end else if (o_loaded && (i_rx_data == NB_BYTE'(CMD_STEP))) begin
                     state    <= ST_STEP;
                     o_enable <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (pk_done_c) begin
                  if (pk_word_c == HALT_INSTR) begin
                     o_loaded <= 1'b1;
                     state    <= ST_IDLE;
                  end else if (addr == LAST_ADDR) begin
                     o_overflow <= 1'b1;
                     state      <= ST_IDLE;
                  end
               end
            end
            ST_RUN: begin
               if (i_halt_reached) begin
                  o_enable <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            ST_STEP: begin
               o_enable <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader (MEM_DEPTH=4): vector table for load/run/step plus multi-cycle sequences.
module tb_inst_loader;

   localparam logic [7:0] L = 8'h4C;
   localparam logic [7:0] R = 8'h52;
   localparam logic [7:0] S = 8'h53;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        halt;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        enable;
   logic        loaded;
   logic        overflow;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   inst_loader #(.MEM_DEPTH(4)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_rx_data        (rx_data),
      .i_rx_valid       (rx_valid),
      .i_halt_reached   (halt),
      .o_inst_mem_wr_en (wr_en),
      .o_inst_mem_addr  (wr_addr),
      .o_inst_mem_data  (wr_data),
      .o_enable         (enable),
      .o_loaded         (loaded),
      .o_overflow       (overflow),
      .o_state          (state)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t wlog[$];

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        h;
      logic        wr;
      logic [31:0] a;
      logic [31:0] w;
      logic        en;
      logic        ld;
      logic        ov;
      logic [1:0]  st;
   } vec_t;
   vec_t vt[$];

   // Record every memory write and confirm it never overlaps a pipeline enable.
   always @(negedge clk) begin
      if (rst === 1'b1 && wr_en === 1'b1) begin
         wlog.push_back('{wr_addr, wr_data});
         total++;
         if (enable !== 1'b0) begin
            bad++;
            $display("FAIL wr_vs_enable: enable=%b during write, required 0", enable);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic h, input logic wr,
                      input logic [31:0] a, input logic [31:0] w, input logic en,
                      input logic ld, input logic ov, input logic [1:0] st);
      vt.push_back('{v, d, h, wr, a, w, en, ld, ov, st});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr"}, 32'(wr_en), 32'd0);
      chk({tag, "_addr"}, wr_addr, 32'd0);
      chk({tag, "_data"}, wr_data, 32'd0);
      chk({tag, "_en"}, 32'(enable), 32'd0);
      chk({tag, "_ld"}, 32'(loaded), 32'd0);
      chk({tag, "_ov"}, 32'(overflow), 32'd0);
      chk({tag, "_st"}, 32'(state), 32'd0);
   endtask

   logic [7:0] b3 [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'hFF, 8'hFF, 8'hFF, 8'hFF};

   initial begin
      rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      halt     = 1'b0;

      // Reset held 3 cycles with random RX traffic
      for (int i = 0; i < 3; i++) begin
         rx_valid = 1'($urandom);
         rx_data  = 8'($urandom);
         tick();
         chk_all_zero($sformatf("reset%0d", i));
      end
      rx_valid = 1'b0;
      rst      = 1'b1;

      // Load 0000_0001 + HALT with one idle cycle between bytes
      add(1, L,     0, 0, 0, 0,            0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0,            0, 0, 0, 1);
      add(1, 8'h00, 0, 0, 0, 0,            0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0,            0, 0, 0, 1);
      add(1, 8'h00, 0, 0, 0, 0,            0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0,            0, 0, 0, 1);
      add(1, 8'h00, 0, 0, 0, 0,            0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0,            0, 0, 0, 1);
      add(1, 8'h01, 0, 1, 0, 32'h1,        0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 4, 0,            0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         add(1, 8'hFF, 0, 0, 4, 0,         0, 0, 0, 1);
         add(0, 8'h00, 0, 0, 4, 0,         0, 0, 0, 1);
      end
      add(1, 8'hFF, 0, 1, 4, 32'hFFFF_FFFF, 0, 1, 0, 0);
      add(0, 8'h00, 0, 0, 8, 0,            0, 1, 0, 0);
      // Step, then run until halt; stray bytes ignored
      add(1, 8'h41, 0, 0, 8, 0,            0, 1, 0, 0);
      add(1, S,     0, 0, 8, 0,            1, 1, 0, 3);
      add(0, 8'h00, 0, 0, 8, 0,            0, 1, 0, 0);
      add(0, 8'h00, 0, 0, 8, 0,            0, 1, 0, 0);
      add(1, R,     0, 0, 8, 0,            1, 1, 0, 2);
      add(0, 8'h00, 0, 0, 8, 0,            1, 1, 0, 2);
      add(1, L,     0, 0, 8, 0,            1, 1, 0, 2);
      add(0, 8'h00, 1, 0, 8, 0,            0, 1, 0, 0);
      add(0, 8'h00, 1, 0, 8, 0,            0, 1, 0, 0);

      for (int i = 0; i < vt.size(); i++) begin
         rx_valid = vt[i].v;
         rx_data  = vt[i].d;
         halt     = vt[i].h;
         tick();
         chk($sformatf("vec%0d_wr", i), 32'(wr_en), 32'(vt[i].wr));
         chk($sformatf("vec%0d_addr", i), wr_addr, vt[i].a);
         if (vt[i].wr) chk($sformatf("vec%0d_data", i), wr_data, vt[i].w);
         chk($sformatf("vec%0d_en", i), 32'(enable), 32'(vt[i].en));
         chk($sformatf("vec%0d_ld", i), 32'(loaded), 32'(vt[i].ld));
         chk($sformatf("vec%0d_ov", i), 32'(overflow), 32'(vt[i].ov));
         chk($sformatf("vec%0d_st", i), 32'(state), 32'(vt[i].st));
      end
      rx_valid = 1'b0;
      halt     = 1'b0;
      idle(2);

      // Back-to-back bytes, including one in each write cycle
      wlog.delete();
      send(L);
      for (int i = 0; i < 12; i++) send(b3[i]);
      idle(3);
      chk("b2b_count", 32'(wlog.size()), 32'd3);
      chk("b2b_addr0", wlog[0].addr, 32'd0);
      chk("b2b_data0", wlog[0].data, 32'h1122_3344);
      chk("b2b_addr1", wlog[1].addr, 32'd4);
      chk("b2b_data1", wlog[1].data, 32'h5566_7788);
      chk("b2b_addr2", wlog[2].addr, 32'd8);
      chk("b2b_data2", wlog[2].data, 32'hFFFF_FFFF);
      chk("b2b_loaded", 32'(loaded), 32'd1);
      chk("b2b_state", 32'(state), 32'd0);

      // Memory fills before HALT: overflow, not loaded, run refused
      wlog.delete();
      send(L);
      for (int w = 0; w < 4; w++)
         for (int b = 0; b < 4; b++) send(8'(16 * w + b + 1));
      idle(2);
      chk("ovf_count", 32'(wlog.size()), 32'd4);
      for (int w = 0; w < 4; w++) begin
         chk($sformatf("ovf_addr%0d", w), wlog[w].addr, 32'(4 * w));
         chk($sformatf("ovf_data%0d", w), wlog[w].data,
             {8'(16 * w + 1), 8'(16 * w + 2), 8'(16 * w + 3), 8'(16 * w + 4)});
      end
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_loaded", 32'(loaded), 32'd0);
      chk("ovf_state", 32'(state), 32'd0);
      chk("ovf_addr_cap", wr_addr, 32'd12);
      send(R);
      chk("ovf_run_state", 32'(state), 32'd0);
      chk("ovf_run_en", 32'(enable), 32'd0);
      send(8'h12);
      send(8'h34);
      idle(2);
      chk("ovf_no_more_wr", 32'(wlog.size()), 32'd4);

      // Reset mid-word discards the partial bytes
      send(L);
      send(8'hAA);
      send(8'hBB);
      rst = 1'b0;
      tick();
      chk_all_zero("midrst");
      rst = 1'b1;
      wlog.delete();
      send(L);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      send(8'h05);
      for (int i = 0; i < 4; i++) send(8'hFF);
      idle(3);
      chk("rst_count", 32'(wlog.size()), 32'd2);
      chk("rst_addr0", wlog[0].addr, 32'd0);
      chk("rst_data0", wlog[0].data, 32'h0000_0005);
      chk("rst_addr1", wlog[1].addr, 32'd4);
      chk("rst_data1", wlog[1].data, 32'hFFFF_FFFF);
      chk("rst_loaded", 32'(loaded), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
